sign_apply_serial: RTL and testbench
====================================

// Module: sign_apply_serial
// PURPOSE
//   Inverse of the absolute-value stage: takes an N-bit unsigned magnitude plus a sign bit
//   and produces the N-bit two's-complement result (negates when sign=1).
//   Bit-serial, LSB-first negation: copy bits up to and including the first '1', invert the rest.
//   Sits after the unsigned datapath and restores signed values before write-back.
//   Valid/ready on both sides; one operand in flight.
// PARAMETERS
//   N  5  magnitude and result width in bits (N >= 2)
// PORTS
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  operand valid
//   in_ready   out  1  block can accept an operand
//   mag        in   N  unsigned magnitude
//   signbit    in   1  1 = negate
//   out_valid  out  1  result valid
//   out_ready  in   1  consumer accepts result
//   out        out  N  two's-complement result
//   ovf        out  1  result not representable in N-bit signed
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; out=0; ovf=0; counter=0; shift reg=0.
//   FSM:
//     IDLE  -> SHIFT on in_valid&&in_ready. Latch mag into shift reg, signbit into sign reg,
//              and ovf = signbit ? (mag > 2^(N-1)) : mag[N-1]. Clear seen_one. cnt=0.
//     SHIFT -> one bit per cycle, LSB first.
//              obit = sign ? (b ^ seen_one) : b. seen_one |= b.
//              obit shifts into out from the MSB side. cnt++.
//              After the N-th SHIFT cycle (cnt==N-1) -> DONE.
//     DONE  -> out_valid=1; out and ovf stable. On out_ready -> IDLE.
//   in_ready=1 only in IDLE. Inputs in SHIFT/DONE are ignored. No bypass.
//   Latency: out_valid rises on the N-th rising edge after the accepting edge.
//   Throughput: one operand per N+2 cycles when out_ready is held high.
//   Arithmetic: result = (-mag) mod 2^N when signbit=1, else mag.
//     mag=0, signbit=1 (negative zero) -> out=0, ovf=0.
//     mag=2^(N-1), signbit=1 -> out = most-negative value, ovf=0.
//   Backpressure: DONE holds out/ovf/out_valid until out_ready, for any number of cycles.
//   out_ready while not in DONE: no effect.
//   Reset mid-SHIFT or in DONE: immediate return to reset values; partial result discarded.
// CONFIGURATION
//   SIGN_APPLY_SAT_EN defined:
//     On entry to DONE with ovf=1, out saturates:
//       signbit=0 -> 2^(N-1)-1
//       signbit=1 -> -2^(N-1)
//     ovf still reported.
//   Not defined: out wraps (mod 2^N), ovf reported only. Timing identical in both builds.
// TESTING (N=5)
//   Reset: rst_n=0 asynchronously mid-SHIFT -> out_valid=0, in_ready=1, out=0 without waiting for clk.
//   Negate: mag=6, signbit=1 -> after 5 edges out=5'b11010, ovf=0.
//     mag=6, signbit=0 -> out=5'b00110.
//   Edges: mag=0, signbit=1 -> 5'b00000, ovf=0.
//     mag=16, signbit=1 -> 5'b10000, ovf=0.
//     mag=16, signbit=0 -> ovf=1; out=5'b10000 (wrap) / 5'b01111 (SIGN_APPLY_SAT_EN).
//   Saturation, negative side: mag=31, signbit=1 -> ovf=1; out=5'b00001 (wrap) / 5'b10000 (SAT).
//   Backpressure: out_ready=0 for 10 cycles in DONE -> out stable, in_ready=0, new in_valid ignored.
//     Then out_ready=1 -> IDLE next edge.
//   Back-to-back: 8 random operands, out_ready=1 -> each accepted every 7 cycles.
//     Results match reference model, in order.

Source files
------------

// File: rtl/sign_apply_serial.sv
// Bit-serial sign application: LSB-first two's-complement negation of a magnitude.
// Optional SIGN_APPLY_SAT_EN saturates out-of-range results instead of wrapping.
module sign_apply_serial #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] mag,
    input  logic         signbit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         ovf
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [CW-1:0] LAST  = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sign_q, sign_d;
    logic          seen_q, seen_d;
    logic          ovf_q, ovf_d;

    logic          b;
    logic          obit;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        seen_d  = seen_q;
        ovf_d   = ovf_q;
        b       = sh_q[0];
        obit    = sign_q ? (b ^ seen_q) : b;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_SHIFT;
                    sh_d    = mag;
                    sign_d  = signbit;
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    // Only -2^(N-1) is reachable from a negated magnitude with MSB set.
                    ovf_d   = signbit ? (mag > MIN_NEG) : mag[N-1];
                end
            end
            S_SHIFT: begin
                sh_d   = sh_q >> 1;
                seen_d = seen_q | b;
                out_d  = {obit, out_q[N-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
`ifdef SIGN_APPLY_SAT_EN
                    if (ovf_q) begin
                        out_d = sign_q ? MIN_NEG : MAX_POS;
                    end
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sign_apply_serial.sv
// Self-checking bench for sign_apply_serial (N=5), directed vectors plus model.
// Build with +define+SIGN_APPLY_SAT_EN to check the saturating variant.
module tb_sign_apply_serial;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] mag = '0;
    logic         signbit = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out;
    logic         ovf;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [N:0] exp_q[$];
    int         acc_q[$];
    logic       prev_ov = 1'b0;
    logic       b2b = 1'b0;
    logic       have_last = 1'b0;
    int         last_acc = 0;

    sign_apply_serial #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mag(mag),
        .signbit(signbit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain modular arithmetic on integers; returns {ovf, out}.
    function automatic logic [N:0] model(input int m, input bit s);
        int  v;
        bit  ov;
        logic [N:0] r;
        v  = s ? ((32 - m) % 32) : m;
        ov = s ? (m > 16) : (m >= 16);
`ifdef SIGN_APPLY_SAT_EN
        if (ov) v = s ? 16 : 15;
`endif
        r = {ov, 5'(v)};
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov <= 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("model_out", int'(out), int'(exp_q[0][N-1:0]));
                    chk("model_ovf", int'(ovf), int'(exp_q[0][N]));
                    if (!prev_ov) chk("latency", cyc - acc_q[0], N + 1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(mag), signbit));
                acc_q.push_back(cyc);
                if (b2b && have_last) chk("b2b_interval", cyc - last_acc, N + 2);
                last_acc  = cyc;
                have_last = 1'b1;
            end
            prev_ov <= out_valid;
        end
    end

    // Drives one operand and checks the result against hand-computed values.
    task automatic run_op(input string name, input logic [N-1:0] m,
                          input logic s, input logic [N-1:0] eo,
                          input logic eov);
        int k;
        @(posedge clk); #1;
        in_valid = 1'b1; mag = m; signbit = s;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk); k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk); k++;
        end
        if (!out_valid) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            chk({name, "_out"}, int'(out), int'(eo));
            chk({name, "_ovf"}, int'(ovf), int'(eov));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] held;
        int k;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk); rst_n = 1'b1;

        run_op("neg6", 5'd6, 1'b1, 5'b11010, 1'b0);
        run_op("pos6", 5'd6, 1'b0, 5'b00110, 1'b0);
        run_op("negzero", 5'd0, 1'b1, 5'b00000, 1'b0);
        run_op("neg16", 5'd16, 1'b1, 5'b10000, 1'b0);
`ifdef SIGN_APPLY_SAT_EN
        run_op("pos16", 5'd16, 1'b0, 5'b01111, 1'b1);
        run_op("neg31", 5'd31, 1'b1, 5'b10000, 1'b1);
`else
        run_op("pos16", 5'd16, 1'b0, 5'b10000, 1'b1);
        run_op("neg31", 5'd31, 1'b1, 5'b00001, 1'b1);
`endif
        run_op("pos15", 5'd15, 1'b0, 5'b01111, 1'b0);
        run_op("neg1", 5'd1, 1'b1, 5'b11111, 1'b0);

        // Backpressure: hold the result in DONE.
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; mag = 5'd9; signbit = 1'b1;
        @(posedge clk); #1;
        mag = 5'd3; signbit = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk); k++;
        end
        chk("bp_reached_done", int'(out_valid), 1);
        held = out;
        chk("bp_value", int'(held), 23);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable", int'(out), int'(held));
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", int'(in_ready), 1);
        chk("bp_release_ov", int'(out_valid), 0);

        // Back-to-back random operands.
        b2b = 1'b1;
        have_last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            mag = 5'($urandom_range(0, 31));
            signbit = 1'($urandom_range(0, 1));
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 20) begin
                @(negedge clk); k++;
            end
            if (!in_ready) chk("b2b_accept_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk); k++;
        end
        chk("b2b_drained", exp_q.size(), 0);
        b2b = 1'b0;

        // Asynchronous reset mid-SHIFT.
        @(posedge clk); #1;
        in_valid = 1'b1; mag = 5'd7; signbit = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out", int'(out), 0);
        chk("arst_ovf", int'(ovf), 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("post_rst", 5'd10, 1'b1, 5'b10110, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
